// File: rtl/e_md_unit.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MD_MADD_EN is defined.
module e_md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,  OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3,
    OP_DIVU  = 4'd4,  OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MADD = 4'd7,
    OP_MADDU = 4'd8,  OP_MSUB  = 4'd9, OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic is_mul, is_div, is_acc, is_sgn, is_mth, is_mtl;
`ifdef MD_MADD_EN
  logic is_sub;
`endif

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_acc = 1'b0;
    is_sgn = 1'b0;
    is_mth = 1'b0;
    is_mtl = 1'b0;
`ifdef MD_MADD_EN
    is_sub = 1'b0;
`endif
    case (md_op)
      OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      OP_MTHI:  is_mth = 1'b1;
      OP_MTLO:  is_mtl = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD:  begin is_acc = 1'b1; is_sgn = 1'b1; end
      OP_MADDU: is_acc = 1'b1;
      OP_MSUB:  begin is_acc = 1'b1; is_sub = 1'b1; is_sgn = 1'b1; end
      OP_MSUBU: begin is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Final RUN cycle: the committing result is forwarded so a back-to-back op sees it.
  logic        finishing, accept;
  logic [31:0] cur_hi, cur_lo;
  assign finishing = (state_q == S_RUN) && (cnt_q == 5'd0);
  assign accept    = start && ((state_q == S_IDLE) || finishing);
  assign cur_hi    = finishing ? res_hi_q : hi_q;
  assign cur_lo    = finishing ? res_lo_q : lo_q;

  // One 64-bit multiplier serves signed and unsigned forms via sign extension.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {{32{is_sgn & rs_d[31]}}, rs_d};
  assign mul_b = {{32{is_sgn & rt_d[31]}}, rt_d};
  assign prod  = mul_a * mul_b;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, uq, ur, quot, rem;
  assign neg_a = is_sgn & rs_d[31];
  assign neg_b = is_sgn & rt_d[31];
  assign mag_a = neg_a ? (32'd0 - rs_d) : rs_d;
  assign mag_b = neg_b ? (32'd0 - rt_d) : rt_d;
  assign uq    = (rt_d == 32'd0) ? 32'd0 : (mag_a / mag_b);
  assign ur    = (rt_d == 32'd0) ? 32'd0 : (mag_a % mag_b);
  assign quot  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign rem   = neg_a ? (32'd0 - ur) : ur;

`ifdef MD_MADD_EN
  logic [63:0] acc;
  assign acc = is_sub ? ({cur_hi, cur_lo} - prod) : ({cur_hi, cur_lo} + prod);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (state_q == S_RUN) begin
      if (cnt_q == 5'd0) begin
        hi_d    = res_hi_q;
        lo_d    = res_lo_q;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end

    if (accept) begin
      if (is_mul || is_acc) begin
        state_d = S_RUN;
        cnt_d   = 5'(MULT_CYCLES - 1);
        {res_hi_d, res_lo_d} = prod;
`ifdef MD_MADD_EN
        if (is_acc) {res_hi_d, res_lo_d} = acc;
`endif
      end else if (is_div) begin
        state_d = S_RUN;
        cnt_d   = 5'(DIV_CYCLES - 1);
        // Divide by zero keeps HI/LO by committing their current values.
        if (rt_d == 32'd0) begin
          res_hi_d = cur_hi;
          res_lo_d = cur_lo;
        end else begin
          res_hi_d = rem;
          res_lo_d = quot;
        end
      end else if (is_mth) begin
        hi_d = rs_d;
      end else if (is_mtl) begin
        lo_d = rs_d;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign md_stall = start | busy;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/e_md_unit.md
# e_md_unit

Execute-stage multiply/divide unit of the 5-stage MIPS pipeline, sitting downstream of the ID/EX pipeline register and consuming its rs/rt operands. It accepts one start pulse per multiply/divide/move-to instruction, runs a fixed-latency multi-cycle operation, and holds the architectural HI/LO registers. It drives `busy` and `md_stall` back to the hazard logic so the pipeline holds any later MD instruction in D while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (and MADD family).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; 0 clears all state immediately.
- `start` input 1: one-cycle request; valid only with a nonzero `md_op`.
- `md_op` input 4: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others are treated as NONE.
- `rs_d` input 32: operand A, forwarded E-stage rs value.
- `rt_d` input 32: operand B, forwarded E-stage rt value.
- `busy` output 1: registered; high while an operation counts down.
- `md_stall` output 1: combinational `start | busy`, to the hazard unit.
- `hi` output 32: registered HI.
- `lo` output 32: registered LO.

## Operation
- States: IDLE, RUN. 5-bit down-counter `cnt`; result holding registers `res_hi`, `res_lo`.
- IDLE + `start` + op 1..4 or 7..10:
  - compute the result into `res_hi`/`res_lo` at that edge;
  - load `cnt` with latency−1;
  - set `busy`, go to RUN.
- RUN: decrement `cnt` each edge. At the edge where `cnt`==0, copy `res_hi`/`res_lo` to `hi`/`lo`, clear `busy`, return to IDLE.
- MULT: signed 32×32→64. MULTU: unsigned. HI = product[63:32], LO = product[31:0].
- DIV: signed; quotient truncates toward zero, remainder takes the dividend's sign. LO = quotient, HI = remainder. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (rt_d==0): the operation still runs full latency; `hi`/`lo` are unchanged at completion.
- MTHI/MTLO in IDLE: write `hi`/`lo` from `rs_d` at the start edge. Single cycle; `busy` stays 0.
- `start` while `busy`=1: ignored entirely (hazard unit guarantees it does not occur; bench checks no state change).
- `start` with op NONE or an unknown op: no effect.
- Reset asserted mid-RUN: aborts the operation. `busy`=0, state IDLE, `cnt`=0, `hi`=`lo`=`res_hi`=`res_lo`=0.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE; `md_stall`=0 while `start`=0.
- `start` sampled at edge N:
  - `busy`=1 after edge N through edge N+L−1, L = MULT_CYCLES or DIV_CYCLES;
  - `hi`/`lo` take the new values and `busy` falls at edge N+L.
- A new `start` is accepted at edge N+L, i.e. back-to-back with no gap cycle.
- `md_stall` rises in the same cycle as `start` (combinational), so the D-stage MD instruction behind it stalls starting that cycle.
- MTHI/MTLO: `hi`/`lo` are visible the cycle after edge N.
- Operand/op values are captured only at the start edge; later changes on `rs_d`/`rt_d` are don't-care.

## Configuration
- `MD_MADD_EN` defined:
  - ops 7..10 are implemented with latency MULT_CYCLES;
  - MADD/MADDU: {HI,LO} += signed/unsigned product;
  - MSUB/MSUBU: {HI,LO} −= product;
  - 64-bit wrap-around; the HI/LO value used is the one current at the start edge.
- `MD_MADD_EN` undefined: ops 7..10 are treated as NONE. No busy, no HI/LO change, and no accumulate datapath is synthesized.

## Test plan
- Reset then MULT rs=0xFFFFFFFE (−2), rt=3:
  - `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA;
  - MULTU with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (−7), rt=2:
  - `busy` high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - DIVU 7/2 gives lo=3, hi=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on the next cycle:
  - each register updates one cycle later;
  - `busy` never rises.
- DIV by zero with hi=0x11, lo=0x22: `busy` high 10 cycles, hi/lo remain 0x11/0x22. Then DIV 0x80000000/−1 gives lo=0x80000000, hi=0.
- MULT started, second `start` (DIVU 9/3) asserted at cycle 2, reset pulsed low at cycle 3:
  - the second `start` has no effect;
  - reset clears `busy` and hi/lo to 0 asynchronously;
  - a MULT 4×5 issued after reset yields lo=20.
- With `MD_MADD_EN`: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0; MSUB 1×1 → hi=0, lo=0xFFFFFFFF. Without the macro, the same sequence leaves hi/lo unchanged.
